div_iter_r2: RTL and testbench
==============================

Name: div_iter_r2

Overview:
- Parametrised, iterative radix-2 restoring unsigned divider for the FPU divide path.
- Computes one quotient bit per clock, MSB first.
- Uses a start/busy/done handshake in place of the fixed two-register pipeline. Trades throughput for area.
- Widths are generic; defaults match the single-precision divide datapath (50-bit dividend, 24-bit divisor).
- Adds divide-by-zero detection.

Parameters:
- NUM_W, 50, dividend and quotient width (>=2)
- DEN_W, 24, divisor and remainder width (>=1, <=NUM_W)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; opa/opb sampled on the rising edge where start=1 and the block is not busy
- opa  input  NUM_W  unsigned dividend
- opb  input  DEN_W  unsigned divisor
- busy  output  1  iteration in progress; start ignored while high
- done  output  1  single-cycle pulse; quo/rem/div_zero valid from this cycle
- quo  output  NUM_W  quotient, floor(opa/opb)
- rem  output  DEN_W  remainder, opa mod opb
- div_zero  output  1  set when the accepted opb was 0

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - While reset=1: state=IDLE; busy=0, done=0, quo=0, rem=0, div_zero=0; internal counter and partial remainder cleared.
- States:
  - IDLE: busy=0. start=1 -> RUN.
  - RUN: busy=1. Stays for exactly NUM_W cycles, then -> DONE.
  - DONE: busy=0, done=1 for one cycle. start=1 -> RUN (back-to-back accepted); else -> IDLE.
- Latency: start sampled at end of cycle 0. busy=1 in cycles 1..NUM_W. done=1 in cycle NUM_W+1. Fixed latency, no early termination.
- Throughput: one division per NUM_W+1 cycles, with back-to-back start issued during the done cycle.
- Operand capture on acceptance:
  - opa loads the dividend shift register; opb loads the divisor register.
  - Partial remainder P (DEN_W+1 bits) is cleared; bit counter is cleared.
  - div_zero is updated to (opb==0).
  - quo and rem are NOT cleared; they update only at completion.
- Each RUN cycle:
  - P' = {P[DEN_W-1:0], dividend MSB}, then shift the dividend left by 1.
  - If P' >= {1'b0, divisor}: P = P' - divisor and shift 1 into the quotient LSB.
  - Else: P = P' and shift 0 in.
  - All compares are unsigned, DEN_W+1 bits wide.
- Completion: on the RUN->DONE edge, quo <= quotient register and rem <= P[DEN_W-1:0].
- Output hold: quo/rem/div_zero hold their values after done until the next completion. div_zero changes at acceptance.
- start rules:
  - start while busy=1 is ignored; operands are not resampled.
  - start held high continuously restarts each time DONE is reached.
- Divide by zero: falls out of the algorithm naturally, with no special datapath. div_zero=1, quo=all ones, rem=opa[DEN_W-1:0].
- opa=0: quo=0, rem=0, normal latency.
- Reset mid-RUN: the operation is aborted; no done pulse; outputs return to 0.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- NUM_W=8, DEN_W=4: opa=100, opb=7, single start pulse
  -> busy high cycles 1..8; done in cycle 9; quo=14, rem=2, div_zero=0.
- NUM_W=8, DEN_W=4: opa=0xA5, opb=0
  -> done in cycle 9; div_zero=1, quo=0xFF, rem=0x5. Then opa=255, opb=1 -> quo=255, rem=0, div_zero=0.
- Defaults: opa=2^49 (562949953421312), opb=3
  -> done in cycle 51; quo=187649984473770, rem=2.
- Back-to-back, NUM_W=8: start during done cycle with opa=9, opb=4
  -> second done exactly 9 cycles later; quo=2, rem=1. A start pulse mid-RUN with other operands has no effect on either result.
- Reset asserted at RUN cycle 4, deasserted 2 cycles later
  -> busy=0, done=0, quo=0, rem=0 immediately; no done pulse. A subsequent start with 100/7 gives quo=14, rem=2 with normal latency.
- Hold: after a completion, keep start=0 for 20 cycles -> quo/rem/div_zero stable; done stays 0.

Source files
------------

// File: rtl/div_iter_r2.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per clock, MSB first,
// start/busy/done handshake with divide-by-zero flag.
module div_iter_r2 #(
  parameter int unsigned NUM_W = 50,
  parameter int unsigned DEN_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] opa,
  input  logic [DEN_W-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo,
  output logic [DEN_W-1:0] rem,
  output logic             div_zero
);

  localparam int unsigned CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
  localparam int unsigned P_W   = DEN_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [NUM_W-1:0] dvd, qr, q_step;
  logic [DEN_W-1:0] dsr;
  logic [P_W-1:0]   p, p_sh, p_step;
  logic [CNT_W-1:0] cnt;
  logic             accept, last, ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    p_sh   = {p[DEN_W-1:0], dvd[NUM_W-1]};
    ge     = (p_sh >= {1'b0, dsr});
    p_step = ge ? (p_sh - {1'b0, dsr}) : p_sh;
    q_step = {qr[NUM_W-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(NUM_W - 1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags track the state being entered so they stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd      <= '0;
      dsr      <= '0;
      p        <= '0;
      qr       <= '0;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      dvd      <= opa;
      dsr      <= opb;
      p        <= '0;
      qr       <= '0;
      cnt      <= '0;
      div_zero <= (opb == '0);
    end else if (state == RUN) begin
      dvd <= {dvd[NUM_W-2:0], 1'b0};
      p   <= p_step;
      qr  <= q_step;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        quo <= q_step;
        rem <= p_step[DEN_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_div_iter_r2.sv
// Directed bench for div_iter_r2: an 8/4-bit instance for handshake and corner
// cases plus a default-width instance for the full-size datapath.
module tb_div_iter_r2;

  logic clk = 1'b0;
  logic reset;

  logic       s8_start;
  logic [7:0] s8_opa;
  logic [3:0] s8_opb;
  logic       s8_busy, s8_done, s8_dz;
  logic [7:0] s8_quo;
  logic [3:0] s8_rem;

  logic        s50_start;
  logic [49:0] s50_opa;
  logic [23:0] s50_opb;
  logic        s50_busy, s50_done, s50_dz;
  logic [49:0] s50_quo;
  logic [23:0] s50_rem;

  int err_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  div_iter_r2 #(.NUM_W(8), .DEN_W(4)) u8 (
    .clk(clk), .reset(reset), .start(s8_start), .opa(s8_opa), .opb(s8_opb),
    .busy(s8_busy), .done(s8_done), .quo(s8_quo), .rem(s8_rem), .div_zero(s8_dz)
  );

  div_iter_r2 u50 (
    .clk(clk), .reset(reset), .start(s50_start), .opa(s50_opa), .opb(s50_opb),
    .busy(s50_busy), .done(s50_done), .quo(s50_quo), .rem(s50_rem), .div_zero(s50_dz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one 8-bit division from the current cycle; returns in its done cycle.
  // With poke set, a start carrying other operands is pulsed mid-RUN.
  task automatic run8(input string tag, input logic [7:0] a, input logic [3:0] b,
                      input logic [7:0] eq, input logic [3:0] er, input logic ez,
                      input bit poke);
    s8_start = 1'b1;
    s8_opa   = a;
    s8_opb   = b;
    tick();
    s8_start = 1'b0;
    check({tag, ".dz_at_accept"}, 64'(s8_dz), 64'(ez));
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("%s.busy_c%0d", tag, c), 64'(s8_busy), 64'd1);
      check($sformatf("%s.done_c%0d", tag, c), 64'(s8_done), 64'd0);
      if (poke && c == 4) begin
        s8_start = 1'b1;
        s8_opa   = 8'd200;
        s8_opb   = 4'd3;
      end
      tick();
      s8_start = 1'b0;
    end
    check({tag, ".done"}, 64'(s8_done), 64'd1);
    check({tag, ".busy_off"}, 64'(s8_busy), 64'd0);
    check({tag, ".quo"}, 64'(s8_quo), 64'(eq));
    check({tag, ".rem"}, 64'(s8_rem), 64'(er));
    check({tag, ".dz"}, 64'(s8_dz), 64'(ez));
  endtask

  initial begin
    reset     = 1'b1;
    s8_start  = 1'b0;
    s8_opa    = '0;
    s8_opb    = '0;
    s50_start = 1'b0;
    s50_opa   = '0;
    s50_opb   = '0;
    tick();
    tick();
    check("rst.busy", 64'(s8_busy), 64'd0);
    check("rst.done", 64'(s8_done), 64'd0);
    check("rst.quo", 64'(s8_quo), 64'd0);
    check("rst.rem", 64'(s8_rem), 64'd0);
    check("rst.dz", 64'(s8_dz), 64'd0);
    check("rst.quo50", 64'(s50_quo), 64'd0);
    reset = 1'b0;
    tick();

    // 100/7 with an ignored mid-RUN start
    run8("d100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b1);
    tick();
    check("d100_7.done_pulse", 64'(s8_done), 64'd0);

    // divide by zero, then a back-to-back 255/1
    run8("dz", 8'hA5, 4'd0, 8'hFF, 4'h5, 1'b1, 1'b0);
    run8("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b0);
    tick();

    // back-to-back 100/7 then 9/4, both with mid-RUN starts
    run8("bb1", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b1);
    run8("bb2", 8'd9, 4'd4, 8'd2, 4'd1, 1'b0, 1'b1);

    // results hold with start low
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("hold.done_%0d", c), 64'(s8_done), 64'd0);
      check($sformatf("hold.quo_%0d", c), 64'(s8_quo), 64'd2);
      check($sformatf("hold.rem_%0d", c), 64'(s8_rem), 64'd1);
      check($sformatf("hold.dz_%0d", c), 64'(s8_dz), 64'd0);
    end

    // default widths: 2^49 / 3
    s50_start = 1'b1;
    s50_opa   = 50'd562949953421312;
    s50_opb   = 24'd3;
    tick();
    s50_start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      check($sformatf("w50.busy_c%0d", c), 64'(s50_busy), 64'd1);
      check($sformatf("w50.done_c%0d", c), 64'(s50_done), 64'd0);
      tick();
    end
    check("w50.done", 64'(s50_done), 64'd1);
    check("w50.quo", 64'(s50_quo), 64'd187649984473770);
    check("w50.rem", 64'(s50_rem), 64'd2);
    check("w50.dz", 64'(s50_dz), 64'd0);
    tick();

    // reset asserted at RUN cycle 4 aborts the operation
    s8_start = 1'b1;
    s8_opa   = 8'd50;
    s8_opb   = 4'd3;
    tick();
    s8_start = 1'b0;
    tick();
    tick();
    tick();
    check("abort.busy_before", 64'(s8_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort.busy", 64'(s8_busy), 64'd0);
    check("abort.done", 64'(s8_done), 64'd0);
    check("abort.quo", 64'(s8_quo), 64'd0);
    check("abort.rem", 64'(s8_rem), 64'd0);
    check("abort.dz", 64'(s8_dz), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("abort.nodone_%0d", c), 64'(s8_done), 64'd0);
      tick();
    end
    run8("post_rst", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule
